bp_update_queue: RTL and testbench

- Sits directly upstream of the two-bit branch predictor's counter RAMs, on the update side.
- Buffers branch-resolution updates from execute in a FIFO.
- Retires each update by a read-modify-write of the 2-bit saturating counter, through the predictor's single-port bank RAM.
- Fetch lookups own the RAM port; this block uses it only when granted.

---
 rtl/bp_update_queue_if.sv | 30 +++
 rtl/bp_update_queue.sv | 190 +++++++++++++++++++
 tb/tb_bp_update_queue.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_update_queue_if.sv
// Update-side bus of the branch predictor update queue: execute updates in, counter RAM port out.
interface bp_update_queue_if #(
  parameter int unsigned INDEX_WIDTH = 9,
  parameter int unsigned BANK_WIDTH  = 2
);
  logic                   upd_valid;
  logic [63:0]            upd_pc;
  logic                   upd_taken;
  logic                   ram_req;
  logic                   ram_gnt;
  logic                   ram_we;
  logic [BANK_WIDTH-1:0]  ram_bank;
  logic [INDEX_WIDTH-1:0] ram_addr;
  logic [1:0]             ram_wdata;
  logic [1:0]             ram_rdata;
  logic                   busy;
  logic [15:0]            drop_cnt;

  // Queue side
  modport master (
    input  upd_valid, upd_pc, upd_taken, ram_gnt, ram_rdata,
    output ram_req, ram_we, ram_bank, ram_addr, ram_wdata, busy, drop_cnt
  );

  // Execute / RAM-arbiter side
  modport slave (
    output upd_valid, upd_pc, upd_taken, ram_gnt, ram_rdata,
    input  ram_req, ram_we, ram_bank, ram_addr, ram_wdata, busy, drop_cnt
  );
endinterface

// File: rtl/bp_update_queue.sv
// Buffers resolved-branch updates and retires each as a read-modify-write of a 2-bit counter.
// Define BP_UPD_BYPASS_EN to forward the last written counter and skip the read for a matching head.
module bp_update_queue #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned INDEX_WIDTH  = 9,
  parameter int unsigned BANK_WIDTH   = 2,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  bp_update_queue_if.master bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned IDX_LSB = BANK_WIDTH + 2;
  localparam int unsigned IDX_MSB = INDEX_WIDTH + BANK_WIDTH + 1;

  typedef struct packed {
    logic [BANK_WIDTH-1:0]  bank;
    logic [INDEX_WIDTH-1:0] idx;
    logic                   taken;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RD, WAIT, WR} state_t;

  state_t                 state_q, state_d;
  entry_t                 fifo_q [DEPTH];
  entry_t                 cur_q, cur_d, head, in_entry;
  logic [PTR_W:0]         wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [1:0]             wcnt_q, wcnt_d;
  logic                   empty, full, push, pop;
  logic                   ram_req_q, ram_req_d, ram_we_q, ram_we_d;
  logic [BANK_WIDTH-1:0]  ram_bank_q, ram_bank_d;
  logic [INDEX_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]             ram_wdata_q, ram_wdata_d;
  logic                   busy_q, busy_d;
  logic [15:0]            drop_cnt_q;
  logic                   unused_pc;
`ifdef BP_UPD_BYPASS_EN
  logic                   fwd_valid_q, fwd_valid_d;
  logic [BANK_WIDTH-1:0]  fwd_bank_q, fwd_bank_d;
  logic [INDEX_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
  logic [1:0]             fwd_val_q, fwd_val_d;
`endif

  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // Extra pointer bit distinguishes full from empty
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push     = bus.upd_valid && !full;
  assign head     = fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign in_entry = '{bank:  bus.upd_pc[BANK_WIDTH+1:2],
                      idx:   bus.upd_pc[IDX_MSB:IDX_LSB],
                      taken: bus.upd_taken};
  assign wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
  assign rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
  assign unused_pc = ^{bus.upd_pc[63:IDX_MSB+1], bus.upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= in_entry;
  end

  // RMW sequencer; RAM-port outputs are registered from the next state
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    wcnt_d      = wcnt_q;
    pop         = 1'b0;
    ram_req_d   = 1'b0;
    ram_we_d    = 1'b0;
    ram_bank_d  = ram_bank_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef BP_UPD_BYPASS_EN
    fwd_valid_d = fwd_valid_q;
    fwd_bank_d  = fwd_bank_q;
    fwd_addr_d  = fwd_addr_q;
    fwd_val_d   = fwd_val_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          cur_d      = head;
          ram_bank_d = head.bank;
          ram_addr_d = head.idx;
          state_d    = RD;
          ram_req_d  = 1'b1;
`ifdef BP_UPD_BYPASS_EN
          if (fwd_valid_q && fwd_bank_q == head.bank && fwd_addr_q == head.idx) begin
            state_d     = WR;
            ram_we_d    = 1'b1;
            ram_wdata_d = ctr_next(fwd_val_q, head.taken);
          end else begin
            fwd_valid_d = 1'b0;
          end
`endif
        end
      end
      RD: begin
        ram_req_d = 1'b1;
        if (bus.ram_gnt) begin
          state_d   = WAIT;
          wcnt_d    = 2'(READ_LATENCY);
          ram_req_d = 1'b0;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 2'd1;
        if (wcnt_q == 2'd1) begin
          state_d     = WR;
          ram_req_d   = 1'b1;
          ram_we_d    = 1'b1;
          ram_wdata_d = ctr_next(bus.ram_rdata, cur_q.taken);
        end
      end
      WR: begin
        ram_req_d = 1'b1;
        ram_we_d  = 1'b1;
        if (bus.ram_gnt) begin
          pop       = 1'b1;
          state_d   = IDLE;
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
`ifdef BP_UPD_BYPASS_EN
          fwd_valid_d = 1'b1;
          fwd_bank_d  = cur_q.bank;
          fwd_addr_d  = cur_q.idx;
          fwd_val_d   = ram_wdata_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      wcnt_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_bank_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
      drop_cnt_q  <= '0;
`ifdef BP_UPD_BYPASS_EN
      fwd_valid_q <= 1'b0;
      fwd_bank_q  <= '0;
      fwd_addr_q  <= '0;
      fwd_val_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      wcnt_q      <= wcnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_bank_q  <= ram_bank_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      if (bus.upd_valid && full && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
`ifdef BP_UPD_BYPASS_EN
      fwd_valid_q <= fwd_valid_d;
      fwd_bank_q  <= fwd_bank_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_val_q   <= fwd_val_d;
`endif
    end
  end

  assign bus.ram_req   = ram_req_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_bank  = ram_bank_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: behavioural counter RAM, write scoreboard, vector table plus corner sequences.
module tb_bp_update_queue;
  localparam int unsigned DEPTH = 8, INDEX_WIDTH = 9, BANK_WIDTH = 2, RL = 1;
  localparam int unsigned NBANK = 1 << BANK_WIDTH, NIDX = 1 << INDEX_WIDTH, NVEC = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_update_queue_if #(.INDEX_WIDTH(INDEX_WIDTH), .BANK_WIDTH(BANK_WIDTH)) bus();

  bp_update_queue #(.DEPTH(DEPTH), .INDEX_WIDTH(INDEX_WIDTH), .BANK_WIDTH(BANK_WIDTH),
                    .READ_LATENCY(RL)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [BANK_WIDTH-1:0]  bank;
    logic [INDEX_WIDTH-1:0] addr;
    logic [1:0]             val;
  } wr_t;

  typedef struct {
    logic [63:0]            pc;
    logic                   taken;
    logic [1:0]             init;
    logic [BANK_WIDTH-1:0]  e_bank;
    logic [INDEX_WIDTH-1:0] e_addr;
    logic [1:0]             e_wdata;
  } vec_t;

  wr_t        sb_q[$];
  vec_t       tv[NVEC];
  logic [1:0] ram_mem [NBANK][NIDX];
  logic [1:0] shadow  [NBANK][NIDX];
  logic       rd_v [4];
  logic [1:0] rd_d [4];
  logic       gnt_en, wr_block;
  int n_vec = 0, n_err = 0;
  int cyc = 0, n_wr = 0, n_rd = 0, last_wr_cyc = 0, occ = 0;
  logic [15:0] exp_drop = '0;

  assign bus.ram_gnt = gnt_en && !(bus.ram_we && wr_block);

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM model and write monitor, sampled mid-cycle
  initial forever begin
    wr_t got, exp;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rd_v[i] = rd_v[i+1];
      rd_d[i] = rd_d[i+1];
    end
    rd_v[3] = 1'b0;
    rd_d[3] = 2'b00;
    bus.ram_rdata = rd_v[0] ? rd_d[0] : 2'b00;
    if (reset && bus.ram_req && bus.ram_gnt) begin
      if (!bus.ram_we) begin
        n_rd++;
        rd_v[RL] = 1'b1;
        rd_d[RL] = ram_mem[bus.ram_bank][bus.ram_addr];
      end else begin
        n_wr++;
        last_wr_cyc = cyc;
        ram_mem[bus.ram_bank][bus.ram_addr] = bus.ram_wdata;
        if (occ > 0) occ--;
        got = '{bank: bus.ram_bank, addr: bus.ram_addr, val: bus.ram_wdata};
        n_vec++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write got bank=%0d addr=0x%0h wdata=%0d required none",
                   got.bank, got.addr, got.val);
        end else begin
          exp = sb_q.pop_front();
          if (got != exp) begin
            n_err++;
            $display("FAIL write got bank=%0d addr=0x%0h wdata=%0d required bank=%0d addr=0x%0h wdata=%0d",
                     got.bank, got.addr, got.val, exp.bank, exp.addr, exp.val);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [1:0] model_ctr(input logic [1:0] c, input logic taken);
    int t;
    t = int'(c) + (taken ? 1 : -1);
    if (t < 0) t = 0;
    if (t > 3) t = 3;
    return 2'(t);
  endfunction

  // Drives one update for one cycle; caller is just past a rising edge
  task automatic send(input logic [63:0] pc, input logic taken, input bit use_tbl,
                      input logic [BANK_WIDTH-1:0] tb_bank, input logic [INDEX_WIDTH-1:0] tb_addr,
                      input logic [1:0] tb_val);
    logic [BANK_WIDTH-1:0]  b;
    logic [INDEX_WIDTH-1:0] a;
    logic [1:0]             v;
    b = BANK_WIDTH'((pc >> 2) & 64'h3);
    a = INDEX_WIDTH'((pc >> 4) & 64'h1FF);
    bus.upd_valid = 1'b1;
    bus.upd_pc    = pc;
    bus.upd_taken = taken;
    if (occ >= int'(DEPTH)) begin
      if (exp_drop != 16'hFFFF) exp_drop++;
    end else begin
      occ++;
      v = model_ctr(shadow[b][a], taken);
      shadow[b][a] = v;
      if (use_tbl) sb_q.push_back('{bank: tb_bank, addr: tb_addr, val: tb_val});
      else         sb_q.push_back('{bank: b, addr: a, val: v});
    end
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic wait_wr(input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (n_wr >= target) break;
    end
    if (n_wr < target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_write got=%0d writes required=%0d", n_wr, target);
    end
  endtask

  initial begin
    int wr0, rd0, t0;
    logic [31:0] snap;
    logic [63:0] pc;

    tv[0] = '{64'h0000_0000_8000_0014, 1'b1, 2'd1, 2'd1, 9'h001, 2'd2};
    tv[1] = '{64'h0000_0000_0000_1238, 1'b1, 2'd3, 2'd2, 9'h123, 2'd3};
    tv[2] = '{64'h0000_0000_0000_0040, 1'b0, 2'd0, 2'd0, 9'h004, 2'd0};
    tv[3] = '{64'h0000_0000_0000_00CC, 1'b0, 2'd2, 2'd3, 9'h00C, 2'd1};
    tv[4] = '{64'hFFFF_FFFF_FFFF_FFF4, 1'b1, 2'd0, 2'd1, 9'h1FF, 2'd1};
    tv[5] = '{64'h0000_0000_0000_2000, 1'b0, 2'd3, 2'd0, 9'h000, 2'd2};

    reset = 1'b0; gnt_en = 1'b0; wr_block = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin rd_v[i] = 1'b0; rd_d[i] = 2'b00; end
    for (int b = 0; b < int'(NBANK); b++)
      for (int a = 0; a < int'(NIDX); a++) begin ram_mem[b][a] = 2'b00; shadow[b][a] = 2'b00; end

    repeat (3) @(negedge clk);
    #1;
    check("rst_req", 32'(bus.ram_req), 0);
    check("rst_we", 32'(bus.ram_we), 0);
    check("rst_bank", 32'(bus.ram_bank), 0);
    check("rst_addr", 32'(bus.ram_addr), 0);
    check("rst_wdata", 32'(bus.ram_wdata), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_drop", 32'(bus.drop_cnt), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    gnt_en = 1'b1;

    // Isolated updates, uncontended port
    for (int i = 0; i < int'(NVEC); i++) begin
      ram_mem[tv[i].e_bank][tv[i].e_addr] = tv[i].init;
      shadow[tv[i].e_bank][tv[i].e_addr]  = tv[i].init;
      wr0 = n_wr;
      t0  = cyc;
      send(tv[i].pc, tv[i].taken, 1'b1, tv[i].e_bank, tv[i].e_addr, tv[i].e_wdata);
      wait_wr(wr0 + 1, 40);
      check("latency", 32'(last_wr_cyc - t0), 32'(3 + RL));
      check("busy_at_wr", 32'(bus.busy), 1);
      @(negedge clk); #1;
      check("busy_after_wr", 32'(bus.busy), 0);
      check("req_after_wr", 32'(bus.ram_req), 0);
      @(posedge clk); #1;
    end

    // Back-to-back updates to one counter
    pc = 64'h540;
    ram_mem[0][9'h054] = 2'd1;
    shadow[0][9'h054]  = 2'd1;
    wr0 = n_wr; rd0 = n_rd;
    send(pc, 1'b1, 1'b0, '0, '0, '0);
    send(pc, 1'b1, 1'b0, '0, '0, '0);
    wait_wr(wr0 + 2, 60);
`ifdef BP_UPD_BYPASS_EN
    check("waw_reads", 32'(n_rd - rd0), 1);
`else
    check("waw_reads", 32'(n_rd - rd0), 2);
`endif
    @(negedge clk); #1;
    check("waw_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;

    // Write grant withheld for five cycles
    ram_mem[2][9'h0A4] = 2'd2;
    shadow[2][9'h0A4]  = 2'd2;
    wr_block = 1'b1;
    wr0 = n_wr;
    send(64'hA48, 1'b1, 1'b0, '0, '0, '0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (bus.ram_we) break;
    end
    check("stall_in_wr", 32'(bus.ram_we), 1);
    check("stall_bank", 32'(bus.ram_bank), 2);
    check("stall_addr", 32'(bus.ram_addr), 32'h0A4);
    check("stall_wdata", 32'(bus.ram_wdata), 3);
    snap = 32'({bus.ram_req, bus.ram_we, bus.ram_bank, bus.ram_addr, bus.ram_wdata});
    repeat (5) begin
      @(negedge clk); #1;
      check("stall_hold", 32'({bus.ram_req, bus.ram_we, bus.ram_bank, bus.ram_addr, bus.ram_wdata}), snap);
      check("stall_no_write", 32'(n_wr), 32'(wr0));
    end
    @(posedge clk); #1;
    wr_block = 1'b0;
    wait_wr(wr0 + 1, 10);
    @(negedge clk); #1;
    check("stall_req_drop", 32'(bus.ram_req), 0);
    repeat (3) @(negedge clk);
    #1;
    check("stall_single_write", 32'(n_wr - wr0), 1);
    @(posedge clk); #1;

    // Overflow while the port is held by fetch
    gnt_en = 1'b0;
    wr0 = n_wr;
    for (int i = 0; i < 10; i++) begin
      ram_mem[0][9'h100 + 9'(i)] = 2'(i % 4);
      shadow[0][9'h100 + 9'(i)]  = 2'(i % 4);
    end
    for (int i = 0; i < 10; i++)
      send(64'h3000 + 64'(i * 16), 1'(i % 2), 1'b0, '0, '0, '0);
    check("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
    check("drop_cnt_two", 32'(bus.drop_cnt), 2);
    check("full_busy", 32'(bus.busy), 1);
    check("full_no_write", 32'(n_wr), 32'(wr0));
    gnt_en = 1'b1;
    wait_wr(wr0 + 8, 200);
    repeat (10) @(negedge clk);
    #1;
    check("drain_writes", 32'(n_wr - wr0), 8);
    check("drain_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;

    // Asynchronous reset while waiting on read data
    rd0 = n_rd; wr0 = n_wr;
    bus.upd_valid = 1'b1; bus.upd_pc = 64'hB54; bus.upd_taken = 1'b1;
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (n_rd != rd0) break;
    end
    check("rst_read_seen", 32'(n_rd - rd0), 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus.ram_req), 0);
    check("mid_rst_we", 32'(bus.ram_we), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    sb_q.delete();
    occ = 0;
    exp_drop = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("post_rst_no_write", 32'(n_wr), 32'(wr0));
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_drop", 32'(bus.drop_cnt), 0);
    check("post_rst_req", 32'(bus.ram_req), 0);

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
